regfile_port_arbiter: RTL and testbench
=======================================

// Module: regfile_port_arbiter
// PURPOSE
//  Shares the single register-file port and the single CPSR port of the ARM7 core between
//  NUM_REQ requesters (ALU, load/store unit, exception sequencer). Round-robin arbitration.
//  Each accepted operation runs through a fixed 4-cycle sequence: strobe, storage latency,
//  response. Sits between the execute-stage units and the register bank / CPSR storage.
// PARAMETERS
//  NUM_REQ  2   number of requesters (index 0 = ALU)
//  ADDR_W   4   register index width (r0..r15)
//  DATA_W   32  register / CPSR data width
// PORTS
//  clk              in   1                  clock; all logic on posedge
//  rst              in   1                  synchronous, active-high reset
//  req_valid        in   NUM_REQ            per-requester op request; held until req_ready
//  req_ready        out  NUM_REQ            one-hot accept (combinational; IDLE only)
//  req_op           in   2*NUM_REQ          op per requester (pkg OP_* codes)
//  req_reg          in   ADDR_W*NUM_REQ     register index (ignored for CPSR ops)
//  req_wdata        in   DATA_W*NUM_REQ     write data (ignored for reads)
//  req_lock         in   NUM_REQ            hold grant after this op (REGFILE_ARB_LOCK_EN only)
//  rsp_valid        out  NUM_REQ            one-cycle completion pulse to the owner
//  rsp_data         out  DATA_W             read result; holds value until next read completes
//  rf_read_en       out  1                  register read strobe
//  rf_read_reg      out  ADDR_W             register read index
//  rf_read_value    in   DATA_W             valid the cycle after rf_read_en
//  rf_write_en      out  1                  register write strobe
//  rf_write_reg     out  ADDR_W             register write index
//  rf_write_value   out  DATA_W             register write data
//  cpsr_read_en     out  1                  CPSR read strobe
//  cpsr_read_value  in   DATA_W             valid the cycle after cpsr_read_en
//  cpsr_write_en    out  1                  CPSR write strobe
//  cpsr_write_value out  DATA_W             CPSR write data
//  busy             out  1                  state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, lock_owner=none, all strobes/rsp_valid=0, rsp_data=0, busy=0.
//  IDLE: winner = first valid requester at or after rr_ptr (wraps NUM_REQ-1 -> 0).
//   req_ready[winner]=1 in that cycle. On that edge: latch op/reg/wdata/id, rr_ptr <= winner+1
//   (mod NUM_REQ), go ISSUE. No valid requesters: stay IDLE, req_ready=0.
//  ISSUE (A+1): exactly one strobe is high, chosen by op: REG_RD->rf_read_en; REG_WR->rf_write_en;
//   CPSR_RD->cpsr_read_en; CPSR_WR->cpsr_write_en. Index/data ports driven from latches. -> WAIT.
//  WAIT (A+2): strobes low; for reads, capture rf_read_value / cpsr_read_value into rsp_data. -> RESP.
//  RESP (A+3): rsp_valid[id]=1 for reads and writes (write ack). -> IDLE; next accept earliest A+4.
//  Index/data outputs hold last driven value when not strobing. Writes leave rsp_data unchanged.
//  Throughput: 1 op / 4 cycles. Single port, strictly in-order: no read/write hazards possible.
//  Requester drops req_valid before ready: request is simply not seen; no error.
//  Reset in any state: op dropped, no rsp_valid; next cycle IDLE with rr_ptr=0.
// CONFIGURATION
//  REGFILE_ARB_LOCK_EN defined: the accepted op with req_lock=1 sets lock_owner=id. While an owner
//   is set, only the owner is eligible in IDLE; rr_ptr is not advanced. lock_owner clears when the
//   owner's op is accepted with req_lock=0 (that op still executes), or when the owner has
//   req_valid=0 and req_lock=0 in IDLE. Gives atomic CPSR read-modify-write.
//  Undefined: req_lock port present but ignored; pure round-robin.
// STRUCTURE
//  regfile_arb_pkg: OP_REG_RD=2'b00, OP_REG_WR=2'b01, OP_CPSR_RD=2'b10, OP_CPSR_WR=2'b11;
//   state codes IDLE/ISSUE/WAIT/RESP.
//  Sub-module rr_picker: combinational one-hot winner from valid vector, rr_ptr and lock mask.
// TESTING
//  1 r5=0x12345678; req0 REG_RD r5 -> rf_read_en=1 with reg 5 at A+1; rsp_valid[0] at A+3;
//    rsp_data=0x12345678.
//  2 After reset, req0 and req1 both REG_WR (r1=0xA, r2=0xB) -> req0 served first, then req1
//    accepted at A+4; r1=0xA, r2=0xB.
//  3 req0 and req1 continuously valid, 4 ops -> grant order 0,1,0,1, one accept every 4 cycles.
//  4 req1 CPSR_WR 0xF0000010 then CPSR_RD -> cpsr_write_en pulse, then rsp_data=0xF0000010.
//  5 rst asserted during WAIT of a req1 read -> no rsp_valid; all strobes 0; next accept goes to req0.
//  6 LOCK_EN: req0 CPSR_RD lock=1, req1 valid throughout, req0 CPSR_WR lock=0 -> req1 accepted only
//    after req0's write is accepted. Without the macro, req1 is accepted between them.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_arb_pkg
// Shared types and constants for the register-file / CPSR port arbiter.
//   op_e    : operation codes carried on req_op (2 bits per requester)
//   state_e : arbiter sequence states (IDLE -> ISSUE -> WAIT -> RESP)
//   ptr_width(): width of a requester index, never narrower than 1 bit
// ---------------------------------------------------------------------------
package regfile_arb_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_REG_RD  = 2'b00,
    OP_REG_WR  = 2'b01,
    OP_CPSR_RD = 2'b10,
    OP_CPSR_WR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // A single requester still needs a 1-bit index so vectors stay legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_port_arbiter_if
// Requester-side bundle of the register-file port arbiter.
//   req_valid  [NUM_REQ]         request, held by the requester until req_ready
//   req_ready  [NUM_REQ]         one-hot accept from the arbiter
//   req_op     [2*NUM_REQ]       op per requester (OP_* codes)
//   req_reg    [ADDR_W*NUM_REQ]  register index per requester
//   req_wdata  [DATA_W*NUM_REQ]  write data per requester
//   req_lock   [NUM_REQ]         keep grant after this op (lock build only)
//   rsp_valid  [NUM_REQ]         one-cycle completion pulse
//   rsp_data   [DATA_W]          last read result
// Handshake: an op transfers on a rising clk edge where req_valid[i] and
// req_ready[i] are both high; req_ready may only rise while the arbiter is
// idle and never depends on anything but req_valid/lock state of this cycle.
// modport master: requester side.  modport slave: arbiter side.
// ---------------------------------------------------------------------------
interface regfile_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2*NUM_REQ-1:0]      req_op;
  logic [ADDR_W*NUM_REQ-1:0] req_reg;
  logic [DATA_W*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_op, req_reg, req_wdata, req_lock,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_reg, req_wdata, req_lock,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/regfile_port_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin winner selection.
//   i_valid [NUM_REQ]  request vector
//   i_ptr   [PTR_W]    highest-priority index this cycle
//   i_mask  [NUM_REQ]  eligibility mask (all ones unless a lock is held)
//   o_grant [NUM_REQ]  one-hot winner (zero when nobody is eligible)
//   o_idx   [PTR_W]    binary index of the winner
//   o_any              a winner exists
// ---------------------------------------------------------------------------
module rr_picker
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [PTR_W-1:0]   i_ptr,
  input  logic [NUM_REQ-1:0] i_mask,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_elig;
  int                 w_cand;

  assign w_elig = i_valid & i_mask;

  // Walk candidates starting at i_ptr, wrapping; the first eligible wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (int'(i_ptr) + k) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!o_any && (j == w_cand) && w_elig[j]) begin
          o_grant[j] = 1'b1;
          o_idx      = PTR_W'(j);
          o_any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_port_arbiter
// Shares the single register-file port and the single CPSR port of the core
// between NUM_REQ requesters (index 0 = ALU) with round-robin arbitration.
// Every accepted op runs a fixed sequence: accept (IDLE) -> strobe (ISSUE)
// -> storage latency / read capture (WAIT) -> rsp_valid pulse (RESP).
// Optional feature macro: REGFILE_ARB_LOCK_EN (grant locking for atomic
// CPSR read-modify-write). Undefined: req_lock is ignored.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_if (slave)           requester bundle (see regfile_port_arbiter_if)
//   rf_read_en/_reg          register read strobe / index
//   rf_read_value            register data, valid the cycle after the strobe
//   rf_write_en/_reg/_value  register write strobe / index / data
//   cpsr_read_en             CPSR read strobe
//   cpsr_read_value          CPSR data, valid the cycle after the strobe
//   cpsr_write_en/_value     CPSR write strobe / data
//   busy                     sequence in progress (state != IDLE)
//   dbg_state                current sequence state
// ---------------------------------------------------------------------------
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  regfile_port_arbiter_if.slave req_if,
  output logic                rf_read_en,
  output logic [ADDR_W-1:0]   rf_read_reg,
  input  logic [DATA_W-1:0]   rf_read_value,
  output logic                rf_write_en,
  output logic [ADDR_W-1:0]   rf_write_reg,
  output logic [DATA_W-1:0]   rf_write_value,
  output logic                cpsr_read_en,
  input  logic [DATA_W-1:0]   cpsr_read_value,
  output logic                cpsr_write_en,
  output logic [DATA_W-1:0]   cpsr_write_value,
  output logic                busy,
  output state_e              dbg_state
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  state_e              r_state;
  state_e              w_next_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  op_e                 r_op;
  logic [PTR_W-1:0]    r_id;
  logic [ADDR_W-1:0]   r_rf_read_reg;
  logic [ADDR_W-1:0]   r_rf_write_reg;
  logic [DATA_W-1:0]   r_rf_write_value;
  logic [DATA_W-1:0]   r_cpsr_write_value;
  logic [DATA_W-1:0]   r_rsp_data;

  logic [NUM_REQ-1:0]  w_grant;
  logic [PTR_W-1:0]    w_grant_idx;
  logic                w_any;
  logic [NUM_REQ-1:0]  w_mask;
  logic                w_accept;
  logic                w_adv_ptr;
  logic [PTR_W-1:0]    w_next_ptr;
  op_e                 w_win_op;
  logic [ADDR_W-1:0]   w_win_reg;
  logic [DATA_W-1:0]   w_win_wdata;
  logic                w_win_lock;

  // ------------------------------------------------------------------
  // Winner selection
  // ------------------------------------------------------------------
  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_valid (req_if.req_valid),
    .i_ptr   (r_rr_ptr),
    .i_mask  (w_mask),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  assign w_accept = (r_state == ST_IDLE) && w_any;

  // Pull the winner's fields out of the flat per-requester buses.
  always_comb begin
    w_win_op    = OP_REG_RD;
    w_win_reg   = '0;
    w_win_wdata = '0;
    w_win_lock  = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant[j]) begin
        w_win_op    = op_e'(req_if.req_op[OP_W*j +: OP_W]);
        w_win_reg   = req_if.req_reg[ADDR_W*j +: ADDR_W];
        w_win_wdata = req_if.req_wdata[DATA_W*j +: DATA_W];
        w_win_lock  = req_if.req_lock[j];
      end
    end
  end

  assign w_next_ptr = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                           : w_grant_idx + PTR_W'(1);

  // ------------------------------------------------------------------
  // Grant lock
  // ------------------------------------------------------------------
`ifdef REGFILE_ARB_LOCK_EN
  logic             r_lock_valid;
  logic [PTR_W-1:0] r_lock_owner;
  logic             w_owner_valid;
  logic             w_owner_lock;

  always_comb begin
    w_mask        = '1;
    w_owner_valid = 1'b0;
    w_owner_lock  = 1'b0;
    if (r_lock_valid) begin
      w_mask = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (r_lock_owner == PTR_W'(j)) begin
          w_mask[j]     = 1'b1;
          w_owner_valid = req_if.req_valid[j];
          w_owner_lock  = req_if.req_lock[j];
        end
      end
    end
  end

  // The pointer is frozen while a lock is held so the round-robin order
  // resumes where it left off once the owner lets go.
  assign w_adv_ptr = !r_lock_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_valid <= 1'b0;
      r_lock_owner <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_any) begin
        // While locked only the owner can win, so an unlocked accept here
        // is always the owner releasing.
        if (w_win_lock) begin
          r_lock_valid <= 1'b1;
          r_lock_owner <= w_grant_idx;
        end else begin
          r_lock_valid <= 1'b0;
        end
      end else if (r_lock_valid && !w_owner_valid && !w_owner_lock) begin
        r_lock_valid <= 1'b0;
      end
    end
  end
`else
  logic w_unused_lock;

  assign w_mask        = '1;
  assign w_adv_ptr     = 1'b1;
  assign w_unused_lock = ^{req_if.req_lock, w_win_lock};
`endif

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_next_state = ST_ISSUE;
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT:  w_next_state = ST_RESP;
      ST_RESP:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    req_if.req_ready = '0;
    req_if.rsp_valid = '0;
    rf_read_en       = 1'b0;
    rf_write_en      = 1'b0;
    cpsr_read_en     = 1'b0;
    cpsr_write_en    = 1'b0;
    case (r_state)
      ST_IDLE: req_if.req_ready = w_grant;
      ST_ISSUE: begin
        case (r_op)
          OP_REG_RD:  rf_read_en    = 1'b1;
          OP_REG_WR:  rf_write_en   = 1'b1;
          OP_CPSR_RD: cpsr_read_en  = 1'b1;
          OP_CPSR_WR: cpsr_write_en = 1'b1;
          default: ;
        endcase
      end
      ST_RESP: begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (r_id == PTR_W'(j)) req_if.rsp_valid[j] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath: op latch, pointer, port-side registers, read capture
  // ------------------------------------------------------------------
  // Port index/data registers only load for the op that uses them, so each
  // port keeps its last driven value while other ops run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr           <= '0;
      r_op               <= OP_REG_RD;
      r_id               <= '0;
      r_rf_read_reg      <= '0;
      r_rf_write_reg     <= '0;
      r_rf_write_value   <= '0;
      r_cpsr_write_value <= '0;
      r_rsp_data         <= '0;
    end else begin
      if (w_accept) begin
        r_op <= w_win_op;
        r_id <= w_grant_idx;
        if (w_adv_ptr) r_rr_ptr <= w_next_ptr;
        case (w_win_op)
          OP_REG_RD: r_rf_read_reg <= w_win_reg;
          OP_REG_WR: begin
            r_rf_write_reg   <= w_win_reg;
            r_rf_write_value <= w_win_wdata;
          end
          OP_CPSR_WR: r_cpsr_write_value <= w_win_wdata;
          default: ;
        endcase
      end
      if (r_state == ST_WAIT) begin
        case (r_op)
          OP_REG_RD:  r_rsp_data <= rf_read_value;
          OP_CPSR_RD: r_rsp_data <= cpsr_read_value;
          default: ;
        endcase
      end
    end
  end

  assign rf_read_reg      = r_rf_read_reg;
  assign rf_write_reg     = r_rf_write_reg;
  assign rf_write_value   = r_rf_write_value;
  assign cpsr_write_value = r_cpsr_write_value;
  assign req_if.rsp_data  = r_rsp_data;
  assign busy             = (r_state != ST_IDLE);
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_port_arbiter
// Directed bench for regfile_port_arbiter (NUM_REQ=2, ADDR_W=4, DATA_W=32).
// A register-bank / CPSR storage model answers the strobes with one cycle of
// read latency. Single-requester ops come from a vector table; arbitration,
// reset-in-flight and lock behaviour are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_regfile_port_arbiter;
  import regfile_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  regfile_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) rif ();

  logic              rf_read_en, rf_write_en, cpsr_read_en, cpsr_write_en, busy;
  logic [ADDR_W-1:0] rf_read_reg, rf_write_reg;
  logic [DATA_W-1:0] rf_read_value, rf_write_value, cpsr_read_value, cpsr_write_value;
  state_e            dbg_state;

  regfile_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_if           (rif),
    .rf_read_en       (rf_read_en),
    .rf_read_reg      (rf_read_reg),
    .rf_read_value    (rf_read_value),
    .rf_write_en      (rf_write_en),
    .rf_write_reg     (rf_write_reg),
    .rf_write_value   (rf_write_value),
    .cpsr_read_en     (cpsr_read_en),
    .cpsr_read_value  (cpsr_read_value),
    .cpsr_write_en    (cpsr_write_en),
    .cpsr_write_value (cpsr_write_value),
    .busy             (busy),
    .dbg_state        (dbg_state)
  );

  // ---------------- storage model ----------------
  logic [DATA_W-1:0] regs [16];
  logic [DATA_W-1:0] cpsr;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h1000_0000 + 32'(i);
      cpsr            <= 32'h0000_00D3;
      rf_read_value   <= '0;
      cpsr_read_value <= '0;
    end else begin
      if (rf_write_en)   regs[rf_write_reg] <= rf_write_value;
      if (rf_read_en)    rf_read_value      <= regs[rf_read_reg];
      if (cpsr_write_en) cpsr               <= cpsr_write_value;
      if (cpsr_read_en)  cpsr_read_value    <= cpsr;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [3:0] strobes();
    return {rf_read_en, rf_write_en, cpsr_read_en, cpsr_write_en};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int id, input logic v, input logic [1:0] op,
                       input logic [3:0] rg, input logic [31:0] wd, input logic lk);
    rif.req_valid[id]         = v;
    rif.req_op[2*id +: 2]     = op;
    rif.req_reg[4*id +: 4]    = rg;
    rif.req_wdata[32*id +: 32] = wd;
    rif.req_lock[id]          = lk;
  endtask

  task automatic clear_reqs();
    rif.req_valid = '0;
    rif.req_op    = '0;
    rif.req_reg   = '0;
    rif.req_wdata = '0;
    rif.req_lock  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_reqs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Call at a negedge; returns #1 after the negedge of the accept cycle.
  task automatic wait_accept(input string name, output int idx);
    idx = -1;
    for (int n = 0; n < 24; n++) begin
      #1;
      if (rif.req_ready != '0) begin
        idx = (rif.req_ready == 2'b01) ? 0 : ((rif.req_ready == 2'b10) ? 1 : 9);
        break;
      end
      @(negedge clk);
    end
    if (idx < 0) begin
      n_checks++;
      $display("FAIL %s: no req_ready within 24 cycles", name);
    end
  endtask

  task automatic run_op(input string tag, input int id, input logic [1:0] op,
                        input logic [3:0] rg, input logic [31:0] wd,
                        input logic [31:0] exp_rd);
    int idx;
    @(negedge clk);
    drive(id, 1'b1, op, rg, wd, 1'b0);
    wait_accept({tag, "_accept"}, idx);
    if (idx < 0) begin
      drive(id, 1'b0, op, rg, wd, 1'b0);
      return;
    end
    check({tag, "_grant"}, 32'(idx), 32'(id));
    @(negedge clk); #1;                          // A+1: ISSUE
    rif.req_valid[id] = 1'b0;
    check({tag, "_issue_strobe"}, 32'(strobes()), 32'(4'b1000 >> op));
    check({tag, "_issue_ready"}, 32'(rif.req_ready), 32'd0);
    case (op)
      2'b00: check({tag, "_rd_reg"}, 32'(rf_read_reg), 32'(rg));
      2'b01: begin
        check({tag, "_wr_reg"}, 32'(rf_write_reg), 32'(rg));
        check({tag, "_wr_val"}, rf_write_value, wd);
      end
      2'b11: check({tag, "_cpsr_val"}, cpsr_write_value, wd);
      default: ;
    endcase
    @(negedge clk); #1;                          // A+2: WAIT
    check({tag, "_wait_strobe"}, 32'(strobes()), 32'd0);
    check({tag, "_wait_rsp"}, 32'(rif.rsp_valid), 32'd0);
    @(negedge clk); #1;                          // A+3: RESP
    check({tag, "_rsp_valid"}, 32'(rif.rsp_valid), 32'(2'b01 << id));
    check({tag, "_rsp_data"}, rif.rsp_data, exp_rd);
    @(negedge clk); #1;                          // A+4: IDLE
    check({tag, "_idle_rsp"}, 32'(rif.rsp_valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [3:0]  rg;
    logic [31:0] wd;
    logic [31:0] exp_rd;   // rsp_data seen in RESP
  } vec_t;

  vec_t vecs [10];

  // ---------------- main ----------------
  initial begin
    int idx, a_prev, a_now;
    logic [1:0] rsp_seen;

    vecs[0] = '{0, OP_REG_WR,  4'd5,  32'h1234_5678, 32'h0000_0000};
    vecs[1] = '{0, OP_REG_RD,  4'd5,  32'h0,         32'h1234_5678};
    vecs[2] = '{1, OP_REG_WR,  4'd15, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[3] = '{1, OP_REG_RD,  4'd15, 32'h0,         32'hDEAD_BEEF};
    vecs[4] = '{0, OP_REG_RD,  4'd0,  32'h0,         32'h1000_0000};
    vecs[5] = '{1, OP_CPSR_WR, 4'd0,  32'hF000_0010, 32'h1000_0000};
    vecs[6] = '{1, OP_CPSR_RD, 4'd0,  32'h0,         32'hF000_0010};
    vecs[7] = '{0, OP_REG_WR,  4'd3,  32'h0000_0000, 32'hF000_0010};
    vecs[8] = '{0, OP_REG_RD,  4'd3,  32'h0,         32'h0000_0000};
    vecs[9] = '{0, OP_REG_RD,  4'd5,  32'h0,         32'h1234_5678};

    clear_reqs();
    do_reset();

    // Reset state
    #1;
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_state",     32'(dbg_state), 32'(ST_IDLE));
    check("rst_strobes",   32'(strobes()), 32'd0);
    check("rst_rsp_valid", 32'(rif.rsp_valid), 32'd0);
    check("rst_rsp_data",  rif.rsp_data, 32'd0);
    check("rst_ready",     32'(rif.req_ready), 32'd0);

    // Single-requester ops from the table
    foreach (vecs[i])
      run_op($sformatf("v%0d", i), vecs[i].id, vecs[i].op, vecs[i].rg, vecs[i].wd, vecs[i].exp_rd);

    // Two simultaneous writes after reset: req0 first, req1 four cycles later
    do_reset();
    drive(0, 1'b1, OP_REG_WR, 4'd1, 32'h0000_000A, 1'b0);
    drive(1, 1'b1, OP_REG_WR, 4'd2, 32'h0000_000B, 1'b0);
    wait_accept("t2_acc0", idx);
    a_prev = cyc;
    check("t2_first", 32'(idx), 32'd0);
    @(negedge clk);
    rif.req_valid[0] = 1'b0;
    wait_accept("t2_acc1", idx);
    check("t2_second", 32'(idx), 32'd1);
    check("t2_spacing", 32'(cyc - a_prev), 32'd4);
    @(negedge clk);
    rif.req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    run_op("t2_rd_r1", 0, OP_REG_RD, 4'd1, 32'h0, 32'h0000_000A);
    run_op("t2_rd_r2", 1, OP_REG_RD, 4'd2, 32'h0, 32'h0000_000B);

    // Continuous contention: grants alternate, one accept per 4 cycles
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    @(negedge clk);
    drive(0, 1'b1, OP_REG_RD, 4'd1, 32'h0, 1'b0);
    drive(1, 1'b1, OP_REG_RD, 4'd2, 32'h0, 1'b0);
    a_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_accept($sformatf("t3_acc%0d", k), idx);
      a_now = cyc;
      check($sformatf("t3_order%0d", k), 32'(idx), 32'(exp_q.pop_front()));
      if (k > 0) check($sformatf("t3_spacing%0d", k), 32'(a_now - a_prev), 32'd4);
      a_prev = a_now;
      @(negedge clk);
    end
    clear_reqs();
    repeat (5) @(negedge clk);

    // Reset during WAIT of a req1 read
    drive(1, 1'b1, OP_REG_RD, 4'd2, 32'h0, 1'b0);
    wait_accept("t5_acc", idx);
    check("t5_grant", 32'(idx), 32'd1);
    @(negedge clk);
    rif.req_valid[1] = 1'b0;
    @(negedge clk); #1;
    check("t5_in_wait", 32'(dbg_state), 32'(ST_WAIT));
    rst = 1'b1;
    @(negedge clk); #1;
    check("t5_rst_busy",    32'(busy), 32'd0);
    check("t5_rst_strobes", 32'(strobes()), 32'd0);
    check("t5_rst_rsp",     32'(rif.rsp_valid), 32'd0);
    rst = 1'b0;
    rsp_seen = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      rsp_seen = rsp_seen | rif.rsp_valid;
    end
    check("t5_no_rsp", 32'(rsp_seen), 32'd0);
    drive(0, 1'b1, OP_REG_RD, 4'd1, 32'h0, 1'b0);
    drive(1, 1'b1, OP_REG_RD, 4'd2, 32'h0, 1'b0);
    wait_accept("t5_next", idx);
    check("t5_next_grant", 32'(idx), 32'd0);
    @(negedge clk);
    clear_reqs();
    repeat (5) @(negedge clk);

    // Lock: req0 CPSR read (lock=1), then CPSR write (lock=0); req1 waiting
    do_reset();
`ifdef REGFILE_ARB_LOCK_EN
    exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd1);
`else
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
`endif
    drive(0, 1'b1, OP_CPSR_RD, 4'd0, 32'h0, 1'b1);
    drive(1, 1'b1, OP_REG_RD, 4'd4, 32'h0, 1'b0);
    wait_accept("t6_acc0", idx);
    check("t6_order0", 32'(idx), 32'(exp_q.pop_front()));
    @(negedge clk);
    drive(0, 1'b1, OP_CPSR_WR, 4'd0, 32'hA000_00C5, 1'b0);
    for (int k = 1; k < 3; k++) begin
      wait_accept($sformatf("t6_acc%0d", k), idx);
      check($sformatf("t6_order%0d", k), 32'(idx), 32'(exp_q.pop_front()));
      @(negedge clk);
      if (idx == 0 || idx == 1) rif.req_valid[idx] = 1'b0;
    end
    clear_reqs();
    repeat (5) @(negedge clk);
    #1;
    check("t6_cpsr_written", cpsr, 32'hA000_00C5);
    check("t6_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
